// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter and write sequencer for one shared WIDTH-bit register.
// Four requesters take turns loading their DataIn slice; outputs are Moore-decoded from registered state.
module shared_reg_arbiter #(
  parameter int unsigned          WIDTH     = 8,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [3:0]           Req,
  input  logic [4*WIDTH-1:0]   DataIn,
  output logic [3:0]           Grant,
  output logic [3:0]           Ack,
  output logic [1:0]           Owner,
  output logic                 Busy,
  output logic [WIDTH-1:0]     RegQ
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_WRITE = 2'd2,
    S_COOL  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_ptr;
  logic [1:0]       w_ptr_nxt;
  logic [1:0]       r_owner;
  logic [1:0]       w_owner_nxt;
  logic [WIDTH-1:0] r_regq;
  logic             w_load;
  logic             w_any;
  logic [1:0]       w_pick;
  logic [WIDTH-1:0] w_slice;

  // Scan from the lowest priority upward so the first match after ptr wins.
  always_comb begin
    logic [1:0] v_idx;
    v_idx  = r_ptr;
    w_any  = |Req;
    w_pick = r_ptr;
    for (int unsigned k = 0; k < 4; k++) begin
      v_idx = r_ptr + 2'(3 - k);
      if (Req[v_idx]) begin
        w_pick = v_idx;
      end
    end
  end

  always_comb begin
    w_slice = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (r_owner == 2'(i)) begin
        w_slice = DataIn[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_owner_nxt = w_pick;
          w_state_nxt = S_GRANT;
        end
      end
      S_GRANT: begin
        w_state_nxt = Req[r_owner] ? S_WRITE : S_IDLE;
      end
      S_WRITE: begin
        w_load      = 1'b1;
        w_ptr_nxt   = r_owner + 2'd1;
        w_state_nxt = S_COOL;
      end
      S_COOL: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
      r_regq  <= RESET_VAL;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_owner <= w_owner_nxt;
      if (w_load) begin
        r_regq <= w_slice;
      end
    end
  end

  always_comb begin
    Grant = '0;
    Ack   = '0;
    if ((r_state == S_GRANT) || (r_state == S_WRITE)) begin
      Grant[r_owner] = 1'b1;
    end
    if (r_state == S_WRITE) begin
      Ack[r_owner] = 1'b1;
    end
  end

  assign Busy  = (r_state != S_IDLE);
  assign Owner = r_owner;
  assign RegQ  = r_regq;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed-vector bench for shared_reg_arbiter: reset, single and contended writes,
// GRANT abort, reset during WRITE and pointer wrap.
module tb_shared_reg_arbiter;

  logic        Clk;
  logic        Rst;
  logic [3:0]  Req;
  logic [31:0] DataIn;
  logic [3:0]  Grant;
  logic [3:0]  Ack;
  logic [1:0]  Owner;
  logic        Busy;
  logic [7:0]  RegQ;

  int unsigned n_vec;
  int unsigned n_err;

  shared_reg_arbiter #(
    .WIDTH     (8),
    .RESET_VAL (8'h00)
  ) u_dut (
    .Clk    (Clk),
    .Rst    (Rst),
    .Req    (Req),
    .DataIn (DataIn),
    .Grant  (Grant),
    .Ack    (Ack),
    .Owner  (Owner),
    .Busy   (Busy),
    .RegQ   (RegQ)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // One full transaction with Req already driven: GRANT, WRITE, COOL, back to IDLE.
  task automatic xact(input logic [1:0] own, input logic [7:0] data);
    logic [3:0] oh;
    oh = 4'b0001 << own;
    tick();
    chk("grant_owner", 32'(Owner), 32'(own));
    chk("grant_grant", 32'(Grant), 32'(oh));
    chk("grant_ack",   32'(Ack),   32'h0);
    chk("grant_busy",  32'(Busy),  32'h1);
    tick();
    chk("write_grant", 32'(Grant), 32'(oh));
    chk("write_ack",   32'(Ack),   32'(oh));
    tick();
    chk("cool_regq",   32'(RegQ),  32'(data));
    chk("cool_grant",  32'(Grant), 32'h0);
    chk("cool_ack",    32'(Ack),   32'h0);
    chk("cool_busy",   32'(Busy),  32'h1);
    tick();
    chk("idle_busy",   32'(Busy),  32'h0);
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    tick();
    tick();
    Rst = 1'b0;
  endtask

  initial begin
    n_vec  = 0;
    n_err  = 0;
    Rst    = 1'b0;
    Req    = 4'b0000;
    DataIn = '0;

    // 1: reset, no requests
    do_reset();
    chk("rst_regq",  32'(RegQ),  32'h00);
    chk("rst_grant", 32'(Grant), 32'h0);
    chk("rst_ack",   32'(Ack),   32'h0);
    chk("rst_busy",  32'(Busy),  32'h0);
    chk("rst_owner", 32'(Owner), 32'h0);
    tick();
    chk("rst_stay_idle", 32'(Busy), 32'h0);

    // 2: single requester 1
    DataIn = {8'h00, 8'h00, 8'hA5, 8'h00};
    Req    = 4'b0010;
    xact(2'd1, 8'hA5);
    Req = 4'b0000;
    tick();
    chk("hold_regq", 32'(RegQ), 32'hA5);

    // 3: all four requesting from ptr=0
    do_reset();
    DataIn = {8'h13, 8'h12, 8'h11, 8'h10};
    Req    = 4'b1111;
    xact(2'd0, 8'h10);
    xact(2'd1, 8'h11);
    xact(2'd2, 8'h12);
    xact(2'd3, 8'h13);
    xact(2'd0, 8'h10);

    // ptr is 1; requester 3 writes, moving ptr to 0
    Req = 4'b1000;
    xact(2'd3, 8'h13);

    // 4: requester 2 drops Req during GRANT
    Req = 4'b0100;
    tick();
    chk("abort_grant", 32'(Grant), 32'h4);
    Req = 4'b0000;
    tick();
    chk("abort_ack",   32'(Ack),   32'h0);
    chk("abort_busy",  32'(Busy),  32'h0);
    chk("abort_regq",  32'(RegQ),  32'h13);
    DataIn = {8'h13, 8'h12, 8'h11, 8'h3C};
    Req    = 4'b0101;
    xact(2'd0, 8'h3C);

    // 6: owner 3 write, then 1001 must pick 0 via ptr wrap
    Req = 4'b1000;
    xact(2'd3, 8'h13);
    Req = 4'b1001;
    xact(2'd0, 8'h3C);
    Req = 4'b0000;
    tick();

    // 5: reset during WRITE
    DataIn = {8'h13, 8'h12, 8'h11, 8'hFF};
    Req    = 4'b0001;
    tick();
    chk("rw_grant", 32'(Grant), 32'h1);
    tick();
    chk("rw_ack_pre", 32'(Ack), 32'h1);
    Rst = 1'b1;
    tick();
    chk("rw_regq",  32'(RegQ),  32'h00);
    chk("rw_ack",   32'(Ack),   32'h0);
    chk("rw_grant0",32'(Grant), 32'h0);
    chk("rw_busy",  32'(Busy),  32'h0);
    Rst = 1'b0;
    Req = 4'b0000;
    tick();
    chk("rw_idle",  32'(Busy),  32'h0);
    chk("rw_hold",  32'(RegQ),  32'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
